pingpong_match_ctrl: RTL and testbench
======================================

PINGPONG_MATCH_CTRL -- requirements
Module: pingpong_match_ctrl

Interface
REQ-001 The block SHALL have parameter WIN_SCORE, default 7, meaning points needed to win a game (range 1..15).
REQ-002 The block SHALL have parameter PAUSE_TICKS, default 16, meaning tick count held in POINT before the next serve (range 1..255).
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock.
REQ-004 The block SHALL have port rst, input, 1, meaning reset (synchronous, active-high, sampled on the rising edge of clk).
REQ-005 The block SHALL have port tick, input, 1, meaning the game-step strobe (one clk wide).
REQ-006 The block SHALL have port start, input, 1, meaning a request to begin or restart a match.
REQ-007 The block SHALL have port miss_a, input, 1, meaning the ball passed paddle A (pulse from the ball engine).
REQ-008 The block SHALL have port miss_b, input, 1, meaning the ball passed paddle B (pulse from the ball engine).
REQ-009 The block SHALL have port engine_run, output, 1, meaning the ball engine may advance.
REQ-010 The block SHALL have port serve_load, output, 1, meaning a one-clk pulse that reloads the ball at centre.
REQ-011 The block SHALL have port serve_dir, output, 1, meaning the serve direction (0 = towards A, 1 = towards B).
REQ-012 The block SHALL have ports score_a and score_b, output, 4 each, meaning the current points.
REQ-013 The block SHALL have port state_o, output, 3, meaning the encoded FSM state.
REQ-014 The block SHALL have ports game_over, output, 1, and winner, output, 1, meaning the match has ended (winner: 0 = A, 1 = B).

Function
REQ-015 The FSM SHALL use states IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4; all other encodings SHALL return to IDLE on the next clk.
REQ-016 IDLE: start=1 SHALL clear both scores, set serve_dir=1 and go to SERVE.
REQ-017 SERVE: on the first tick, serve_load SHALL pulse for exactly 1 clk, with the transition to RALLY on the same edge.
REQ-018 RALLY: engine_run=1; miss_a SHALL increment score_b and miss_b SHALL increment score_a, then go to POINT; engine_run=0 from the next clk.
REQ-019 If miss_a and miss_b are high in the same clk, the block SHALL ignore both, stay in RALLY and score nothing.
REQ-020 Misses outside RALLY SHALL be ignored.
REQ-021 POINT: the pause counter SHALL load PAUSE_TICKS on entry and decrement per tick; at 0 it SHALL go to OVER if the win condition is met, otherwise to SERVE.
REQ-022 serve_dir SHALL be updated on POINT entry so that the ball serves towards the player who lost the point.
REQ-023 Win condition (macro absent): a score is greater than or equal to WIN_SCORE.
REQ-024 Scores SHALL saturate at 15 and never wrap.
REQ-025 OVER: game_over=1 and winner held; start=1 SHALL behave exactly as in IDLE.
REQ-026 start SHALL be ignored in SERVE, RALLY and POINT.
REQ-027 All outputs SHALL be registered; serve_load latency from the qualifying tick SHALL be 1 clk.

Reset
REQ-028 rst=1 SHALL force state IDLE and set engine_run=0, serve_load=0, serve_dir=1, score_a=0, score_b=0, game_over=0, winner=0, and pause counter=0.
REQ-029 rst SHALL override every other input, including mid-rally and mid-pause; there SHALL be no initial blocks.

Configuration
REQ-030 With PINGPONG_DEUCE_EN defined, the win condition SHALL require score greater than or equal to WIN_SCORE and a lead of at least 2 (deuce).
REQ-031 With PINGPONG_DEUCE_EN defined, if both scores reach 15 without a 2-point lead, the higher score SHALL win, and A SHALL win on a tie.
REQ-032 With PINGPONG_DEUCE_EN absent, the deuce logic SHALL not be synthesized.

Structure
REQ-033 The package pingpong_pkg SHALL hold the state enum, SCORE_W=4, DIR_TO_A/DIR_TO_B constants and the default WIN_SCORE.
REQ-034 The pause counter SHALL be the sub-module pingpong_tick_timer (load, tick, count, done).

Verification
REQ-035 The bench SHALL check: rst, then start, then one tick -> serve_load pulse 1 clk, state=RALLY, engine_run=1.
REQ-036 The bench SHALL check: in RALLY, miss_a pulse -> score_b=1, state=POINT, serve_dir=0; after 16 ticks -> SERVE.
REQ-037 The bench SHALL check: 7 consecutive miss_b with macro absent -> score_a=7, game_over=1, winner=0; a further miss -> score unchanged.
REQ-038 The bench SHALL check: simultaneous miss_a and miss_b -> no score change, state remains RALLY.
REQ-039 The bench SHALL check: with PINGPONG_DEUCE_EN defined and score 7-6 -> no game over; at 8-6 -> game_over=1, winner=0.
REQ-040 The bench SHALL check: rst asserted mid-POINT with score 3-2 -> next clk IDLE, scores 0-0, engine_run=0.

Source files
------------

// File: rtl/pingpong_pkg.sv
// Shared types and constants for the pingpong match controller.
// Holds the FSM state encoding, score width, serve directions and default win score.
package pingpong_pkg;

  localparam int SCORE_W           = 4;
  localparam int DEFAULT_WIN_SCORE = 7;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

  localparam logic DIR_TO_A = 1'b0;
  localparam logic DIR_TO_B = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_RALLY = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // Scores stop at 15 rather than wrapping back to zero.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/pingpong_match_ctrl_if.sv
// Bus between the match controller and the ball engine / score display.
// master = ball engine side, slave = match controller.
interface pingpong_match_ctrl_if;
  import pingpong_pkg::*;

  logic               tick;
  logic               start;
  logic               miss_a;
  logic               miss_b;
  logic               engine_run;
  logic               serve_load;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic [2:0]         state_o;
  logic               game_over;
  logic               winner;

  modport master (
    output tick, start, miss_a, miss_b,
    input  engine_run, serve_load, serve_dir, score_a, score_b, state_o, game_over, winner
  );

  modport slave (
    input  tick, start, miss_a, miss_b,
    output engine_run, serve_load, serve_dir, score_a, score_b, state_o, game_over, winner
  );

endinterface

// File: rtl/pingpong_tick_timer.sv
// Pause counter: loads PAUSE_TICKS, counts down one step per tick, done when empty.
module pingpong_tick_timer #(
  parameter int PAUSE_TICKS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic done
);

  localparam logic [7:0] LOAD_VAL = 8'(PAUSE_TICKS);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (tick && (count != '0)) begin
      count <= count - 8'd1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/pingpong_match_ctrl.sv
// Pingpong match controller: serve / rally / point-pause / game-over sequencing and scoring.
// Define PINGPONG_DEUCE_EN to require a 2-point lead (deuce) to win.
module pingpong_match_ctrl
  import pingpong_pkg::*;
#(
  parameter int WIN_SCORE   = DEFAULT_WIN_SCORE,
  parameter int PAUSE_TICKS = 16
) (
  input logic                 clk,
  input logic                 rst,
  pingpong_match_ctrl_if.slave bus
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_a_q, score_a_d;
  logic [SCORE_W-1:0] score_b_q, score_b_d;
  logic               serve_dir_q, serve_dir_d;
  logic               serve_load_q, serve_load_d;
  logic               engine_run_q;
  logic               game_over_q;
  logic               winner_q, winner_d;
  logic               timer_load;
  logic               timer_done;
  logic               win_met;

  pingpong_tick_timer #(
    .PAUSE_TICKS(PAUSE_TICKS)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .tick (bus.tick),
    .done (timer_done)
  );

`ifdef PINGPONG_DEUCE_EN
  // Deuce: need WIN_SCORE and a 2-point lead; a 15-15 deadlock ends the match.
  always_comb begin
    win_met = ((score_a_q >= WIN_VAL) && ({1'b0, score_a_q} >= {1'b0, score_b_q} + 5'd2)) ||
              ((score_b_q >= WIN_VAL) && ({1'b0, score_b_q} >= {1'b0, score_a_q} + 5'd2)) ||
              ((score_a_q == SCORE_MAX) && (score_b_q == SCORE_MAX));
  end
`else
  always_comb begin
    win_met = (score_a_q >= WIN_VAL) || (score_b_q >= WIN_VAL);
  end
`endif

  always_comb begin
    state_d      = state_q;
    score_a_d    = score_a_q;
    score_b_d    = score_b_q;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    serve_load_d = 1'b0;
    timer_load   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          score_a_d   = '0;
          score_b_d   = '0;
          serve_dir_d = DIR_TO_B;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (bus.tick) begin
          serve_load_d = 1'b1;
          state_d      = ST_RALLY;
        end
      end
      ST_RALLY: begin
        // A double miss is ambiguous, so neither side is credited.
        if (bus.miss_a ^ bus.miss_b) begin
          if (bus.miss_a) begin
            score_b_d   = sat_inc(score_b_q);
            serve_dir_d = DIR_TO_A;
          end else begin
            score_a_d   = sat_inc(score_a_q);
            serve_dir_d = DIR_TO_B;
          end
          timer_load = 1'b1;
          state_d    = ST_POINT;
        end
      end
      ST_POINT: begin
        if (timer_done) begin
          if (win_met) begin
            state_d  = ST_OVER;
            winner_d = (score_b_q > score_a_q);
          end else begin
            state_d = ST_SERVE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      score_a_q    <= '0;
      score_b_q    <= '0;
      serve_dir_q  <= DIR_TO_B;
      serve_load_q <= 1'b0;
      engine_run_q <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      score_a_q    <= score_a_d;
      score_b_q    <= score_b_d;
      serve_dir_q  <= serve_dir_d;
      serve_load_q <= serve_load_d;
      engine_run_q <= (state_d == ST_RALLY);
      game_over_q  <= (state_d == ST_OVER);
      winner_q     <= winner_d;
    end
  end

  assign bus.state_o    = state_q;
  assign bus.score_a    = score_a_q;
  assign bus.score_b    = score_b_q;
  assign bus.serve_dir  = serve_dir_q;
  assign bus.serve_load = serve_load_q;
  assign bus.engine_run = engine_run_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_pingpong_match_ctrl.sv
// Scoreboard bench for pingpong_match_ctrl: a rule-level match model predicts every cycle.
// Honours PINGPONG_DEUCE_EN in the model's win rule.
module tb_pingpong_match_ctrl;

  localparam int WIN   = 7;
  localparam int PAUSE = 16;

  localparam int P_IDLE  = 0;
  localparam int P_SERVE = 1;
  localparam int P_RALLY = 2;
  localparam int P_POINT = 3;
  localparam int P_OVER  = 4;

  typedef struct {
    int st;
    int sa;
    int sb;
    bit run;
    bit load;
    bit dir;
    bit over;
    bit win;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pingpong_match_ctrl_if bus ();

  pingpong_match_ctrl #(
    .WIN_SCORE  (WIN),
    .PAUSE_TICKS(PAUSE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model of the match as seen from outside
  int m_phase = P_IDLE;
  int m_sa = 0, m_sb = 0, m_pause = 0;
  bit m_dir = 1'b1, m_win = 1'b0, m_load = 1'b0;

  function automatic bit win_rule(input int a, input int b);
`ifdef PINGPONG_DEUCE_EN
    return ((a >= WIN) && (a - b >= 2)) || ((b >= WIN) && (b - a >= 2)) || ((a == 15) && (b == 15));
`else
    return (a >= WIN) || (b >= WIN);
`endif
  endfunction

  function automatic int plus_one(input int s);
    return (s >= 15) ? 15 : s + 1;
  endfunction

  task automatic model_step(input bit r, input bit t, input bit s, input bit ma, input bit mb);
    if (r) begin
      m_phase = P_IDLE; m_sa = 0; m_sb = 0; m_dir = 1'b1;
      m_win = 1'b0; m_load = 1'b0; m_pause = 0;
      return;
    end
    m_load = 1'b0;
    case (m_phase)
      P_IDLE, P_OVER: if (s) begin
        m_sa = 0; m_sb = 0; m_dir = 1'b1; m_phase = P_SERVE;
      end
      P_SERVE: if (t) begin
        m_load = 1'b1; m_phase = P_RALLY;
      end
      P_RALLY: if (ma != mb) begin
        if (ma) begin m_sb = plus_one(m_sb); m_dir = 1'b0; end
        else    begin m_sa = plus_one(m_sa); m_dir = 1'b1; end
        m_pause = PAUSE;
        m_phase = P_POINT;
      end
      P_POINT: begin
        if (m_pause == 0) begin
          if (win_rule(m_sa, m_sb)) begin
            m_phase = P_OVER;
            m_win   = (m_sb > m_sa);
          end else begin
            m_phase = P_SERVE;
          end
        end else if (t) begin
          m_pause = m_pause - 1;
        end
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic applyStimulus(input bit r, input bit t, input bit s, input bit ma, input bit mb);
    exp_t e;
    @(negedge clk);
    rst        = r;
    bus.tick   = t;
    bus.start  = s;
    bus.miss_a = ma;
    bus.miss_b = mb;
    model_step(r, t, s, ma, mb);
    e.st   = m_phase;
    e.sa   = m_sa;
    e.sb   = m_sb;
    e.run  = (m_phase == P_RALLY);
    e.load = m_load;
    e.dir  = m_dir;
    e.over = (m_phase == P_OVER);
    e.win  = m_win;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("state_o",    int'(bus.state_o),    e.st);
    cmp("score_a",    int'(bus.score_a),    e.sa);
    cmp("score_b",    int'(bus.score_b),    e.sb);
    cmp("engine_run", int'(bus.engine_run), int'(e.run));
    cmp("serve_load", int'(bus.serve_load), int'(e.load));
    cmp("serve_dir",  int'(bus.serve_dir),  int'(e.dir));
    cmp("game_over",  int'(bus.game_over),  int'(e.over));
    cmp("winner",     int'(bus.winner),     int'(e.win));
  endtask

  // Monitor: each issued cycle has one expected record, checked just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  // Serves if needed, then the given side misses; optionally waits out the pause.
  task automatic playPoint(input bit a_loses, input bit finish_pause);
    for (int g = 0; g < 64 && m_phase != P_RALLY; g++) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, a_loses, !a_loses);
    if (finish_pause)
      for (int g = 0; g < 300 && m_phase == P_POINT; g++) applyStimulus(0, 1, 0, 0, 0);
  endtask

  initial begin
    bus.tick = 1'b0; bus.start = 1'b0; bus.miss_a = 1'b0; bus.miss_b = 1'b0;

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < PAUSE; i++) applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);

    for (int i = 0; i < 7; i++) playPoint(1'b0, 1'b1);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 1, 0);

    applyStimulus(0, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      playPoint(1'b1, 1'b1);
      playPoint(1'b0, 1'b1);
    end
    playPoint(1'b0, 1'b1);
    playPoint(1'b0, 1'b1);

    applyStimulus(0, 0, 1, 0, 0);
    playPoint(1'b0, 1'b1);
    playPoint(1'b1, 1'b1);
    playPoint(1'b0, 1'b1);
    playPoint(1'b1, 1'b1);
    playPoint(1'b0, 1'b0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 5) == 0));
    end

    applyStimulus(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
